// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared car state, floor indices and floor position helper
package elevator_pkg;

  typedef enum logic [2:0] {IDLE, UP, DN, DOOR, FAULT} car_state_t;

  localparam int FLOOR1 = 0;
  localparam int FLOOR2 = 1;
  localparam int FLOOR3 = 2;

  function automatic int floor_pos(input int floor_idx, input int travel_cyc);
    return floor_idx * travel_cyc;
  endfunction

endpackage

// File: rtl/door_timer.sv
// rtl/door_timer.sv - door dwell timer emitting a repeating close pulse
// obstruct input present only when ELEVATOR_CAR_OBSTRUCT_EN is defined
module door_timer
  import elevator_pkg::*;
#(
  parameter int DOOR_CYC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
`ifdef ELEVATOR_CAR_OBSTRUCT_EN
  input  logic obstruct,
`endif
  output logic close
);

  localparam int CNT_W = $clog2(DOOR_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DOOR_CYC - 1);

  logic [CNT_W-1:0] cnt;
  logic             hold;

`ifdef ELEVATOR_CAR_OBSTRUCT_EN
  assign hold = clear | obstruct;
`else
  assign hold = clear;
`endif

  // The count restarts on each pulse so close repeats every DOOR_CYC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      close <= 1'b0;
    end else if (hold) begin
      cnt   <= '0;
      close <= 1'b0;
    end else if (enable) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        close <= 1'b1;
      end else begin
        cnt   <= cnt + 1'b1;
        close <= 1'b0;
      end
    end else begin
      close <= 1'b0;
    end
  end

endmodule

// File: rtl/elevator_car.sv
// rtl/elevator_car.sv - car/shaft plant model answering the elevator controller
// optional obstruct input enabled by ELEVATOR_CAR_OBSTRUCT_EN
module elevator_car
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 100,
  parameter int INIT_FLOOR = 0,
  parameter int POS_W      = $clog2(2*TRAVEL_CYC+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             open,
`ifdef ELEVATOR_CAR_OBSTRUCT_EN
  input  logic             obstruct,
`endif
  output logic             red1_reg,
  output logic             red2_reg,
  output logic             red3_reg,
  output logic             red1_up,
  output logic             red2_up,
  output logic             red3_up,
  output logic             red1_down,
  output logic             red2_down,
  output logic             red3_down,
  output logic             close,
  output logic [POS_W-1:0] pos,
  output logic             fault
);

  localparam logic [POS_W-1:0] P1       = POS_W'(floor_pos(FLOOR1, TRAVEL_CYC));
  localparam logic [POS_W-1:0] P2       = POS_W'(floor_pos(FLOOR2, TRAVEL_CYC));
  localparam logic [POS_W-1:0] P3       = POS_W'(floor_pos(FLOOR3, TRAVEL_CYC));
  localparam logic [POS_W-1:0] POS_INIT = POS_W'(floor_pos(INIT_FLOOR, TRAVEL_CYC));

  car_state_t       state, state_next;
  logic [POS_W-1:0] pos_next;
  logic [2:0]       up_pls, dn_pls;
  logic             at_floor;
  logic             step_up, step_dn;
  logic             door_en, door_clr;

  assign red1_reg = (pos == P1);
  assign red2_reg = (pos == P2);
  assign red3_reg = (pos == P3);
  assign at_floor = red1_reg | red2_reg | red3_reg;

  always_comb begin
    state_next = state;
    pos_next   = pos;
    case (state)
      IDLE: begin
        if (up && down)            state_next = FAULT;
        else if (up)               state_next = UP;
        else if (down)             state_next = DN;
        else if (open && at_floor) state_next = DOOR;
      end
      UP: begin
        if (down || (up && pos == P3)) state_next = FAULT;
        else if (!up)                  state_next = (open && at_floor) ? DOOR : IDLE;
        else                           pos_next   = pos + 1'b1;
      end
      DN: begin
        if (up || (down && pos == P1)) state_next = FAULT;
        else if (!down)                state_next = (open && at_floor) ? DOOR : IDLE;
        else                           pos_next   = pos - 1'b1;
      end
      DOOR: begin
        if (up || down) state_next = FAULT;
        else if (!open) state_next = IDLE;
      end
      FAULT:   state_next = FAULT;
      default: state_next = FAULT;
    endcase
  end

  assign step_up = (state == UP) && (state_next == UP);
  assign step_dn = (state == DN) && (state_next == DN);

  // Arrival pulses are registered alongside pos so they coincide with the new position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pos    <= POS_INIT;
      up_pls <= '0;
      dn_pls <= '0;
    end else begin
      state  <= state_next;
      pos    <= pos_next;
      up_pls <= {3{step_up}} & {pos_next == P3, pos_next == P2, pos_next == P1};
      dn_pls <= {3{step_dn}} & {pos_next == P3, pos_next == P2, pos_next == P1};
    end
  end

  assign {red3_up, red2_up, red1_up}       = up_pls;
  assign {red3_down, red2_down, red1_down} = dn_pls;
  assign fault = (state == FAULT);

  // Gating with up/down keeps close quiet on the edge that trips the interlock.
  assign door_en  = (state == DOOR) && open && !up && !down;
  assign door_clr = (state != DOOR) || !open;

  door_timer #(
    .DOOR_CYC (DOOR_CYC)
  ) u_door_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (door_en),
    .clear    (door_clr),
`ifdef ELEVATOR_CAR_OBSTRUCT_EN
    .obstruct (obstruct),
`endif
    .close    (close)
  );

endmodule

// File: tb/tb_elevator_car.sv
// tb/tb_elevator_car.sv - directed self-checking bench for elevator_car
module tb_elevator_car;

  localparam int POS_W = 4;

  logic             clk = 1'b0;
  logic             rst, up, down, open;
`ifdef ELEVATOR_CAR_OBSTRUCT_EN
  logic             obstruct;
`endif
  logic             red1_reg, red2_reg, red3_reg;
  logic             red1_up, red2_up, red3_up;
  logic             red1_down, red2_down, red3_down;
  logic             close, fault;
  logic [POS_W-1:0] pos;

  int n_assert = 0;
  int n_fail   = 0;
  int up_seen;

  elevator_car #(
    .TRAVEL_CYC (4),
    .DOOR_CYC   (3),
    .INIT_FLOOR (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (up),
    .down      (down),
    .open      (open),
`ifdef ELEVATOR_CAR_OBSTRUCT_EN
    .obstruct  (obstruct),
`endif
    .red1_reg  (red1_reg),
    .red2_reg  (red2_reg),
    .red3_reg  (red3_reg),
    .red1_up   (red1_up),
    .red2_up   (red2_up),
    .red3_up   (red3_up),
    .red1_down (red1_down),
    .red2_down (red2_down),
    .red3_down (red3_down),
    .close     (close),
    .pos       (pos),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] regs();
    return {red3_reg, red2_reg, red1_reg};
  endfunction

  function automatic logic [2:0] ups();
    return {red3_up, red2_up, red1_up};
  endfunction

  function automatic logic [2:0] dns();
    return {red3_down, red2_down, red1_down};
  endfunction

  initial begin
    rst = 1'b1; up = 1'b0; down = 1'b0; open = 1'b0;
`ifdef ELEVATOR_CAR_OBSTRUCT_EN
    obstruct = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    check("rst_pos",   pos,    0);
    check("rst_regs",  regs(), 3'b001);
    check("rst_ups",   ups(),  0);
    check("rst_dns",   dns(),  0);
    check("rst_close", close,  0);
    check("rst_fault", fault,  0);

    // Hold up from floor 1 all the way to overtravel
    up = 1'b1;
    tick();
    check("up_latency_pos", pos, 0);
    tick();
    check("up_pos1", pos, 1);
    check("red1_drop", regs(), 3'b000);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check("up_pos", pos, i);
      if (i == 4)      check("red2_up_pulse", ups(), 3'b010);
      else if (i == 8) check("red3_up_pulse", ups(), 3'b100);
      else             check("up_no_pulse",   ups(), 3'b000);
    end
    check("top_regs", regs(), 3'b100);
    tick();
    check("overtravel_fault", fault, 1);
    check("overtravel_pos",   pos,   8);
    check("overtravel_ups",   ups(), 0);
    tick();
    check("overtravel_hold", pos, 8);
    rst = 1'b1; up = 1'b0;
    tick();
    rst = 1'b0;
    check("rst2_fault", fault, 0);
    check("rst2_pos",   pos,   0);

    // Stop at floor 2 and dwell with the door open
    up = 1'b1;
    tick();
    repeat (4) tick();
    check("f2_pos", pos, 4);
    up = 1'b0; open = 1'b1;
    tick();
    check("door_pos", pos, 4);
    tick(); check("door_c1", close, 0);
    tick(); check("door_c2", close, 0);
    tick(); check("close_first", close, 1);
    tick(); check("door_c4", close, 0);
    tick(); check("door_c5", close, 0);
    tick(); check("close_second", close, 1);
    open = 1'b0;
    tick();
    check("door_exit_close", close, 0);
    up = 1'b1;
    tick();
    check("idle_up_nofault", fault, 0);
    check("idle_up_pos", pos, 4);
    tick();
    check("up_from_f2", pos, 5);

    // Halt between floors; open must be ignored
    up = 1'b0; open = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midshaft_close", close,  0);
      check("midshaft_pos",   pos,    5);
      check("midshaft_regs",  regs(), 0);
      check("midshaft_fault", fault,  0);
    end
    open = 1'b0;

    // Continue to floor 3 then descend to floor 1
    up = 1'b1;
    tick();
    repeat (3) tick();
    check("f3_pos", pos, 8);
    up = 1'b0;
    tick();
    down = 1'b1;
    tick();
    check("dn_latency_pos", pos, 8);
    up_seen = 0;
    for (int i = 7; i >= 0; i--) begin
      tick();
      check("dn_pos", pos, i);
      if (ups() != 3'b000) up_seen++;
      if (i == 4)      check("red2_down_pulse", dns(), 3'b010);
      else if (i == 0) check("red1_down_pulse", dns(), 3'b001);
      else             check("dn_no_pulse",     dns(), 3'b000);
    end
    check("dn_no_up_pulses", up_seen, 0);
    tick();
    check("undertravel_fault", fault, 1);
    check("undertravel_pos",   pos,   0);
    check("undertravel_dns",   dns(), 0);
    down = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Conflicting commands and sticky fault
    up = 1'b1; down = 1'b1;
    tick();
    check("conflict_fault", fault, 1);
    up = 1'b0; down = 1'b0; open = 1'b1;
    tick();
    check("sticky_fault1", fault, 1);
    check("sticky_close",  close, 0);
    down = 1'b1;
    tick();
    check("sticky_fault2", fault, 1);
    check("sticky_pos",    pos,   0);
    down = 1'b0; open = 1'b0;
    rst = 1'b1;
    tick();
    check("fault_cleared", fault, 0);
    rst = 1'b0;
    tick();
    check("fault_stays_clear", fault, 0);
    check("fault_clear_pos",   pos,   0);

    // Door interlock
    open = 1'b1;
    tick();
    up = 1'b1;
    tick();
    check("interlock_fault", fault, 1);
    check("interlock_close", close, 0);
    up = 1'b0; open = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

`ifdef ELEVATOR_CAR_OBSTRUCT_EN
    open = 1'b1;
    tick();
    obstruct = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("obstruct_close", close, 0);
    end
    obstruct = 1'b0;
    tick(); check("obstruct_c6", close, 0);
    tick(); check("obstruct_c7", close, 0);
    tick(); check("obstruct_first", close, 1);
    open = 1'b0;
    tick();
`endif

    // Reset mid-motion
    up = 1'b1;
    tick();
    repeat (6) tick();
    check("mid_pos", pos, 6);
    rst = 1'b1;
    tick();
    check("midrst_pos",  pos,    0);
    check("midrst_regs", regs(), 3'b001);
    check("midrst_ups",  ups(),  0);
    rst = 1'b0; up = 1'b0;
    tick();
    check("postrst_ups", ups(), 0);
    check("postrst_pos", pos,   0);
    tick();
    check("postrst_fault", fault, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
